// File: rtl/keyed_lut_bank_if.sv
// keyed_lut_bank_if: key-load handshake and LUT channel bus for keyed_lut_bank
// Ports (as seen by the slave/DUT):
//   key_start, key_bit, key_valid -> serial key load in; key_ready <- accept strobe
//   sel -> per-channel selects; lut_out, armed, load_done <- channel outputs and status
interface keyed_lut_bank_if #(
    parameter int NUM_LUT = 4,
    parameter int SEL_W   = 2
);
    logic                     key_start;
    logic                     key_bit;
    logic                     key_valid;
    logic                     key_ready;
    logic [NUM_LUT*SEL_W-1:0] sel;
    logic [NUM_LUT-1:0]       lut_out;
    logic                     armed;
    logic                     load_done;
    modport master (
        output key_start, key_bit, key_valid, sel,
        input  key_ready, lut_out, armed, load_done
    );
    modport slave (
        input  key_start, key_bit, key_valid, sel,
        output key_ready, lut_out, armed, load_done
    );
endinterface

// File: rtl/keyed_lut_bank.sv
// keyed_lut_bank: NUM_LUT key-programmable LUT channels with serial key load and arm FSM
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - keyed_lut_bank_if.slave: key_start/key_bit/key_valid/key_ready load handshake,
//          sel in, lut_out/armed/load_done out
module keyed_lut_bank #(
    parameter int NUM_LUT = 4,
    parameter int SEL_W   = 2,
    parameter int OUT_REG = 1
) (
    input logic clk,
    input logic rst,
    keyed_lut_bank_if.slave bus
);
    localparam int LUT_SZ   = 1 << SEL_W;
    localparam int KEY_BITS = NUM_LUT * LUT_SZ;
    localparam int CNT_W    = KEY_BITS > 1 ? $clog2(KEY_BITS) : 1;
    typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;
    state_t              state_q, state_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                accept;
    logic [NUM_LUT-1:0]  lut_c;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end
    // key_start wins over any bit presented in the same cycle
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        accept  = (state_q == LOAD) && bus.key_valid && !bus.key_start;
        if (bus.key_start) begin
            state_d = LOAD;
            cnt_d   = '0;
        end else if (accept) begin
            key_d[cnt_q] = bus.key_bit;
            if (cnt_q == CNT_W'(KEY_BITS - 1)) begin
                state_d = ARMED;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end
    for (genvar i = 0; i < NUM_LUT; i++) begin : g_ch
        logic [LUT_SZ-1:0] slice;
        assign slice    = key_q[i*LUT_SZ +: LUT_SZ];
        assign lut_c[i] = slice[bus.sel[i*SEL_W +: SEL_W]];
    end
    if (OUT_REG != 0) begin : g_reg
        logic [NUM_LUT-1:0] out_q;
        // a restart zeroes the output on the same edge that drops armed
        always_ff @(posedge clk) begin
            if (rst) out_q <= '0;
            else     out_q <= (state_q == ARMED && !bus.key_start) ? lut_c : '0;
        end
        assign bus.lut_out = out_q;
    end else begin : g_comb
        assign bus.lut_out = (state_q == ARMED) ? lut_c : '0;
    end
    assign bus.key_ready = state_q == LOAD;
    assign bus.armed     = state_q == ARMED;
    assign bus.load_done = done_q;
endmodule

// File: tb/tb_keyed_lut_bank.sv
// tb_keyed_lut_bank: directed checks of key load, arm, restart, reset and LUT outputs
module tb_keyed_lut_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;
    always #5 clk = ~clk;
    keyed_lut_bank_if #(.NUM_LUT(4), .SEL_W(2)) b ();
    keyed_lut_bank #(.NUM_LUT(4), .SEL_W(2), .OUT_REG(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(b.slave)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        if (b.load_done) done_cnt++;
    endtask
    task automatic do_start(input logic v, input logic kb);
        b.key_start = 1'b1;
        b.key_valid = v;
        b.key_bit   = kb;
        tick();
        b.key_start = 1'b0;
        b.key_valid = 1'b0;
        chk("start_armed", 32'(b.armed), 0);
        chk("start_lut", 32'(b.lut_out), 0);
        chk("start_ready", 32'(b.key_ready), 1);
    endtask
    task automatic send_bits(input logic [15:0] k, input int lo, input int hi, input bit gaps);
        for (int i = lo; i < hi; i++) begin
            if (gaps) begin
                b.key_valid = 1'b0;
                tick();
            end
            b.key_valid = 1'b1;
            b.key_bit   = k[i];
            chk("ready", 32'(b.key_ready), 1);
            tick();
        end
        b.key_valid = 1'b0;
    endtask
    task automatic lut_at(input string tag, input logic [7:0] s, input logic [3:0] exp);
        b.sel = s;
        tick();
        chk(tag, 32'(b.lut_out), 32'(exp));
    endtask
    initial begin
        b.key_start = 1'b0;
        b.key_bit   = 1'b0;
        b.key_valid = 1'b0;
        b.sel       = 8'h00;
        tick();
        tick();
        chk("rst_armed", 32'(b.armed), 0);
        chk("rst_ready", 32'(b.key_ready), 0);
        chk("rst_done", 32'(b.load_done), 0);
        chk("rst_lut", 32'(b.lut_out), 0);
        rst = 1'b0;
        b.sel = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            b.key_valid = 1'($urandom_range(0, 1));
            b.key_bit   = 1'($urandom_range(0, 1));
            tick();
            chk("idle_quiet", {26'd0, b.armed, b.key_ready, b.lut_out}, 0);
        end
        b.key_valid = 1'b0;
        // back-to-back load of A5C3
        b.sel = 8'b01010101;
        done_cnt = 0;
        do_start(1'b0, 1'b0);
        send_bits(16'hA5C3, 0, 16, 1'b0);
        chk("armed", 32'(b.armed), 1);
        chk("done_pulse", 32'(b.load_done), 1);
        chk("ready_off", 32'(b.key_ready), 0);
        chk("lut_latency", 32'(b.lut_out), 0);
        tick();
        chk("done_clear", 32'(b.load_done), 0);
        chk("lut_55", 32'(b.lut_out), 32'h9);
        lut_at("lut_00", 8'h00, 4'b0101);
        chk("done_once", 32'(done_cnt), 1);
        // same key with a gap before every bit
        done_cnt = 0;
        do_start(1'b0, 1'b0);
        send_bits(16'hA5C3, 0, 15, 1'b1);
        chk("gap_not_yet", 32'(b.armed), 0);
        send_bits(16'hA5C3, 15, 16, 1'b1);
        chk("gap_armed", 32'(b.armed), 1);
        lut_at("gap_55", 8'h55, 4'b1001);
        lut_at("gap_aa", 8'hAA, 4'b0110);
        lut_at("gap_ff", 8'hFF, 4'b1010);
        lut_at("gap_00", 8'h00, 4'b0101);
        chk("gap_done_once", 32'(done_cnt), 1);
        // restart after 7 bits; bit offered with key_start must be dropped
        do_start(1'b0, 1'b0);
        send_bits(16'hFFFF, 0, 7, 1'b0);
        do_start(1'b1, 1'b0);
        send_bits(16'hA5C3, 0, 15, 1'b0);
        chk("rs_not_yet", 32'(b.armed), 0);
        send_bits(16'hA5C3, 15, 16, 1'b0);
        chk("rs_armed", 32'(b.armed), 1);
        lut_at("rs_55", 8'h55, 4'b1001);
        lut_at("rs_aa", 8'hAA, 4'b0110);
        // reload zero key from ARMED
        do_start(1'b0, 1'b0);
        send_bits(16'h0000, 0, 16, 1'b0);
        chk("zero_armed", 32'(b.armed), 1);
        lut_at("zero_00", 8'h00, 4'b0000);
        lut_at("zero_55", 8'h55, 4'b0000);
        lut_at("zero_aa", 8'hAA, 4'b0000);
        lut_at("zero_ff", 8'hFF, 4'b0000);
        // reset in the middle of a load
        do_start(1'b0, 1'b0);
        send_bits(16'hA5C3, 0, 10, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_armed", 32'(b.armed), 0);
        chk("mrst_ready", 32'(b.key_ready), 0);
        b.key_valid = 1'b1;
        b.key_bit   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("mrst_idle", {30'd0, b.armed, b.key_ready}, 0);
        end
        b.key_valid = 1'b0;
        do_start(1'b0, 1'b0);
        send_bits(16'hFFFF, 0, 15, 1'b0);
        chk("mrst_not_yet", 32'(b.armed), 0);
        send_bits(16'hFFFF, 15, 16, 1'b0);
        chk("mrst_armed2", 32'(b.armed), 1);
        lut_at("ones_00", 8'h00, 4'b1111);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
